sonar_varredura_n: RTL

//  Parametrised scan sequencer for the sonar: steps the servo through N_POS positions, waits for settling,

---
 rtl/sonar_varredura_n.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/sonar_varredura_n.sv
// Sonar scan sequencer: steps the servo, waits for settling, triggers one measurement per position
// and streams "<angle>,<distance>#" to the UART. Optional measurement timeout via SONAR_TIMEOUT_EN.
module sonar_varredura_n #(
    parameter int unsigned N_POS     = 8,
    parameter int unsigned POS_W     = 3,
    parameter int unsigned DIGITOS   = 3,
    parameter int unsigned T_ESPERA  = 100_000_000,
    parameter int unsigned T_TIMEOUT = 2_000_000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ligar,
    input  logic                   modo,
    input  logic [8*DIGITOS-1:0]   angulo,
    input  logic [4*DIGITOS-1:0]   medida,
    input  logic                   pronto_medida,
    input  logic                   pronto_serial,
    output logic                   medir,
    output logic [POS_W-1:0]       posicao,
    output logic                   partida_serial,
    output logic [6:0]             dados_ascii,
    output logic [4*DIGITOS-1:0]   distancia,
    output logic                   fim_posicao,
    output logic                   fim_varredura,
    output logic [3:0]             db_estado
);

    localparam int unsigned N_CHARS = 2*DIGITOS + 2;
    localparam int unsigned IDX_W   = $clog2(N_CHARS);
    localparam int unsigned DIST_W  = 4*DIGITOS;
    localparam int unsigned T_MAX   = (T_ESPERA > T_TIMEOUT) ? T_ESPERA : T_TIMEOUT;
    localparam int unsigned TMR_W   = $clog2(T_MAX + 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_POS - 1);

    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        ESPERA         = 4'd1,
        MEDE           = 4'd2,
        AGUARDA_MEDIDA = 4'd3,
        TRANSMITE      = 4'd4,
        AGUARDA_TX     = 4'd5,
        PROXIMA_POS    = 4'd6
    } estado_t;

    estado_t              state_q, state_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic                 dir_q, dir_d;
    logic [DIST_W-1:0]    dist_q, dist_d;
    logic                 bang_q, bang_d;
    logic [6:0]           ascii_q, ascii_d;
    logic                 medir_q, medir_d;
    logic                 partida_q, partida_d;
    logic                 fim_pos_q, fim_pos_d;
    logic                 fim_var_q, fim_var_d;
    logic [6:0]           char_c;
    logic [POS_W-1:0]     nxt_c;
    logic                 unused_angulo_c;

    // Bit 7 of every angle byte is don't-care.
    always_comb begin
        unused_angulo_c = 1'b0;
        for (int unsigned i = 0; i < DIGITOS; i++) begin
            unused_angulo_c = unused_angulo_c ^ angulo[8*i+7];
        end
    end

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        idx_d     = idx_q;
        pos_d     = pos_q;
        dir_d     = dir_q;
        dist_d    = dist_q;
        bang_d    = bang_q;
        ascii_d   = ascii_q;
        fim_var_d = 1'b0;
        nxt_c     = '0;
        char_c    = 7'h00;

        case (state_q)
            INICIAL: begin
                if (ligar) begin
                    state_d = ESPERA;
                    tmr_d   = '0;
                end
            end
            ESPERA: begin
                if (tmr_q == TMR_W'(T_ESPERA - 1)) begin
                    state_d = MEDE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            MEDE: begin
                state_d = AGUARDA_MEDIDA;
                idx_d   = '0;
                tmr_d   = '0;
            end
            AGUARDA_MEDIDA: begin
                if (pronto_medida) begin
                    dist_d  = medida;
                    bang_d  = 1'b0;
                    state_d = TRANSMITE;
                end
`ifdef SONAR_TIMEOUT_EN
                else if (tmr_q == TMR_W'(T_TIMEOUT - 1)) begin
                    dist_d  = {DIGITOS{4'h9}};
                    bang_d  = 1'b1;
                    state_d = TRANSMITE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
`endif
            end
            TRANSMITE: begin
                state_d = AGUARDA_TX;
            end
            AGUARDA_TX: begin
                if (pronto_serial) begin
                    if (idx_q == IDX_W'(N_CHARS - 1)) begin
                        state_d = PROXIMA_POS;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = TRANSMITE;
                    end
                end
            end
            PROXIMA_POS: begin
                state_d = ligar ? ESPERA : INICIAL;
                tmr_d   = '0;
                if (N_POS == 1) begin
                    pos_d     = '0;
                    fim_var_d = 1'b1;
                end else if (modo) begin
                    if (pos_q == POS_LAST) begin
                        pos_d     = '0;
                        fim_var_d = 1'b1;
                    end else begin
                        pos_d = pos_q + POS_W'(1);
                    end
                end else begin
                    // Ping-pong: bounce off either end, flag arrival at an end.
                    if (!dir_q) begin
                        nxt_c = (pos_q == POS_LAST) ? pos_q - POS_W'(1) : pos_q + POS_W'(1);
                    end else begin
                        nxt_c = (pos_q == '0) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                    end
                    pos_d = nxt_c;
                    if (nxt_c == POS_LAST) begin
                        dir_d     = 1'b1;
                        fim_var_d = 1'b1;
                    end else if (nxt_c == '0) begin
                        dir_d     = 1'b0;
                        fim_var_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = INICIAL;
            end
        endcase

        // Frame character for the index about to be transmitted.
        for (int unsigned i = 0; i < DIGITOS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                char_c = angulo[8*(DIGITOS-i)-2 -: 7];
            end
            if (idx_d == IDX_W'(DIGITOS + 1 + i)) begin
                char_c = {3'b011, dist_d[4*(DIGITOS-i)-1 -: 4]};
            end
        end
        if (idx_d == IDX_W'(DIGITOS)) begin
            char_c = 7'h2C;
        end
        if (idx_d == IDX_W'(N_CHARS - 1)) begin
            char_c = bang_q ? 7'h21 : 7'h23;
        end

        if (state_d == TRANSMITE) begin
            ascii_d = char_c;
        end

        medir_d   = (state_d == MEDE);
        partida_d = (state_d == TRANSMITE);
        fim_pos_d = (state_d == PROXIMA_POS);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= INICIAL;
            tmr_q     <= '0;
            idx_q     <= '0;
            pos_q     <= '0;
            dir_q     <= 1'b0;
            dist_q    <= '0;
            bang_q    <= 1'b0;
            ascii_q   <= '0;
            medir_q   <= 1'b0;
            partida_q <= 1'b0;
            fim_pos_q <= 1'b0;
            fim_var_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            idx_q     <= idx_d;
            pos_q     <= pos_d;
            dir_q     <= dir_d;
            dist_q    <= dist_d;
            bang_q    <= bang_d;
            ascii_q   <= ascii_d;
            medir_q   <= medir_d;
            partida_q <= partida_d;
            fim_pos_q <= fim_pos_d;
            fim_var_q <= fim_var_d;
        end
    end

    assign medir          = medir_q;
    assign posicao        = pos_q;
    assign partida_serial = partida_q;
    assign dados_ascii    = ascii_q;
    assign distancia      = dist_q;
    assign fim_posicao    = fim_pos_q;
    assign fim_varredura  = fim_var_q;
    assign db_estado      = state_q;

endmodule
